// File: rtl/as2650_bus_arbiter.sv
// Bus arbiter between the as2650 core and one DMA master: round-robin grant,
// SETUP/STROBE/DONE/TURN access sequencing, wait states, ext_rdy watchdog.
module as2650_bus_arbiter #(
    parameter int unsigned ADR_W   = 13,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned WAIT_W  = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WAIT_W-1:0] wait_cfg,
    input  logic              cpu_opreq,
    input  logic              cpu_rw,
    input  logic              cpu_m_io,
    input  logic [ADR_W-1:0]  cpu_adr,
    input  logic [DATA_W-1:0] cpu_dout,
    output logic [DATA_W-1:0] cpu_din,
    output logic              cpu_opack,
    input  logic              dma_req,
    input  logic              dma_rw,
    input  logic [ADR_W-1:0]  dma_adr,
    input  logic [DATA_W-1:0] dma_dout,
    output logic [DATA_W-1:0] dma_din,
    output logic              dma_ack,
    output logic              dma_grant,
    output logic [ADR_W-1:0]  ext_adr,
    output logic [DATA_W-1:0] ext_dout,
    output logic              ext_oeb,
    input  logic [DATA_W-1:0] ext_din,
    output logic              ext_cs_mem,
    output logic              ext_cs_io,
    output logic              ext_oe,
    output logic              ext_we,
    input  logic              ext_rdy,
    output logic              bus_err
);

    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_STROBE = 3'd2,
        S_DONE   = 3'd3,
        S_TURN   = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic              own_dma_q, own_dma_d;
    logic              rw_q, rw_d;
    logic              mem_q, mem_d;
    logic              last_dma_q, last_dma_d;
    logic [WAIT_W-1:0] wcnt_q, wcnt_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [ADR_W-1:0]  ext_adr_q, ext_adr_d;
    logic [DATA_W-1:0] ext_dout_q, ext_dout_d;
    logic [DATA_W-1:0] cpu_din_q, cpu_din_d;
    logic [DATA_W-1:0] dma_din_q, dma_din_d;
    logic              cs_mem_q, cs_mem_d;
    logic              cs_io_q, cs_io_d;
    logic              oe_q, oe_d;
    logic              we_q, we_d;
    logic              oeb_q, oeb_d;
    logic              cpu_opack_q, cpu_opack_d;
    logic              dma_ack_q, dma_ack_d;
    logic              dma_grant_q, dma_grant_d;
    logic              bus_err_q, bus_err_d;

    logic              win_dma_c;
    logic              timeout_c;
    logic              active_c;
    logic [DATA_W-1:0] rd_cap_c;

    // DMA wins if alone, or if both request and the CPU was served last
    assign win_dma_c = dma_req && (!cpu_opreq || !last_dma_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        timeout_c = 1'b0;
        case (state_q)
            S_IDLE:   if (cpu_opreq || dma_req) state_d = S_SETUP;
            S_SETUP:  state_d = S_STROBE;
            S_STROBE: begin
                if (wcnt_q == '0 && ext_rdy) begin
                    state_d = S_DONE;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    state_d   = S_DONE;
                    timeout_c = 1'b1;
                end
            end
            S_DONE:   state_d = S_TURN;
            S_TURN:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        own_dma_d  = own_dma_q;
        rw_d       = rw_q;
        mem_d      = mem_q;
        last_dma_d = last_dma_q;
        wcnt_d     = wcnt_q;
        wd_d       = wd_q;
        ext_adr_d  = ext_adr_q;
        ext_dout_d = ext_dout_q;
        cpu_din_d  = cpu_din_q;
        dma_din_d  = dma_din_q;
        rd_cap_c   = timeout_c ? '1 : ext_din;

        // Latch the winner's request so later input changes cannot disturb it
        if (state_q == S_IDLE && state_d == S_SETUP) begin
            own_dma_d = win_dma_c;
            wcnt_d    = wait_cfg;
            if (win_dma_c) begin
                rw_d       = dma_rw;
                mem_d      = 1'b1;
                ext_adr_d  = dma_adr;
                ext_dout_d = dma_dout;
            end else begin
                rw_d       = cpu_rw;
                mem_d      = cpu_m_io;
                ext_adr_d  = cpu_adr;
                ext_dout_d = cpu_dout;
            end
        end

        if (state_q == S_SETUP) wd_d = '0;

        if (state_q == S_STROBE) begin
            wd_d = wd_q + WD_W'(1);
            if (wcnt_q != '0) wcnt_d = wcnt_q - WAIT_W'(1);
        end

        if (state_q == S_STROBE && state_d == S_DONE && !rw_q) begin
            if (own_dma_q) dma_din_d = rd_cap_c;
            else           cpu_din_d = rd_cap_c;
        end

        if (state_q == S_DONE) last_dma_d = own_dma_q;

        active_c    = (state_d == S_SETUP) || (state_d == S_STROBE);
        cs_mem_d    = active_c && mem_d;
        cs_io_d     = active_c && !mem_d;
        oe_d        = (state_d == S_STROBE) && !rw_d;
        we_d        = (state_d == S_STROBE) && rw_d;
        // Writes keep driving through DONE for hold time
        oeb_d       = !(rw_d && (active_c || state_d == S_DONE));
        cpu_opack_d = (state_d == S_DONE) && !own_dma_d;
        dma_ack_d   = (state_d == S_DONE) && own_dma_d;
        dma_grant_d = own_dma_d && (active_c || state_d == S_DONE);
        bus_err_d   = timeout_c;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            own_dma_q   <= 1'b0;
            rw_q        <= 1'b0;
            mem_q       <= 1'b0;
            last_dma_q  <= 1'b1;
            wcnt_q      <= '0;
            wd_q        <= '0;
            ext_adr_q   <= '0;
            ext_dout_q  <= '0;
            cpu_din_q   <= '0;
            dma_din_q   <= '0;
            cs_mem_q    <= 1'b0;
            cs_io_q     <= 1'b0;
            oe_q        <= 1'b0;
            we_q        <= 1'b0;
            oeb_q       <= 1'b1;
            cpu_opack_q <= 1'b0;
            dma_ack_q   <= 1'b0;
            dma_grant_q <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            own_dma_q   <= own_dma_d;
            rw_q        <= rw_d;
            mem_q       <= mem_d;
            last_dma_q  <= last_dma_d;
            wcnt_q      <= wcnt_d;
            wd_q        <= wd_d;
            ext_adr_q   <= ext_adr_d;
            ext_dout_q  <= ext_dout_d;
            cpu_din_q   <= cpu_din_d;
            dma_din_q   <= dma_din_d;
            cs_mem_q    <= cs_mem_d;
            cs_io_q     <= cs_io_d;
            oe_q        <= oe_d;
            we_q        <= we_d;
            oeb_q       <= oeb_d;
            cpu_opack_q <= cpu_opack_d;
            dma_ack_q   <= dma_ack_d;
            dma_grant_q <= dma_grant_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign cpu_din    = cpu_din_q;
    assign cpu_opack  = cpu_opack_q;
    assign dma_din    = dma_din_q;
    assign dma_ack    = dma_ack_q;
    assign dma_grant  = dma_grant_q;
    assign ext_adr    = ext_adr_q;
    assign ext_dout   = ext_dout_q;
    assign ext_oeb    = oeb_q;
    assign ext_cs_mem = cs_mem_q;
    assign ext_cs_io  = cs_io_q;
    assign ext_oe     = oe_q;
    assign ext_we     = we_q;
    assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_as2650_bus_arbiter.sv
// Self-checking bench for as2650_bus_arbiter: directed scenarios plus random
// single-master accesses compared against an access-level timing/data model.
module tb_as2650_bus_arbiter;

    localparam int unsigned ADR_W   = 13;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned WAIT_W  = 4;
    localparam int unsigned TIMEOUT = 255;

    logic              clk = 1'b0;
    logic              reset;
    logic [WAIT_W-1:0] wait_cfg;
    logic              cpu_opreq, cpu_rw, cpu_m_io;
    logic [ADR_W-1:0]  cpu_adr;
    logic [DATA_W-1:0] cpu_dout, cpu_din;
    logic              cpu_opack;
    logic              dma_req, dma_rw;
    logic [ADR_W-1:0]  dma_adr;
    logic [DATA_W-1:0] dma_dout, dma_din;
    logic              dma_ack, dma_grant;
    logic [ADR_W-1:0]  ext_adr;
    logic [DATA_W-1:0] ext_dout, ext_din;
    logic              ext_oeb, ext_cs_mem, ext_cs_io, ext_oe, ext_we, ext_rdy, bus_err;

    int checks   = 0;
    int failures = 0;

    // Per-access measurements filled in by do_access
    int                m_iter, m_setup, m_strobe, m_oe, m_we, m_csm, m_csio, m_oeb, m_grant;
    logic              m_ack_dma, m_err, m_timed, m_turn_clean;
    logic [DATA_W-1:0] m_din, m_dout;
    logic [ADR_W-1:0]  m_adr;

    as2650_bus_arbiter #(
        .ADR_W(ADR_W), .DATA_W(DATA_W), .WAIT_W(WAIT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .wait_cfg(wait_cfg),
        .cpu_opreq(cpu_opreq), .cpu_rw(cpu_rw), .cpu_m_io(cpu_m_io), .cpu_adr(cpu_adr),
        .cpu_dout(cpu_dout), .cpu_din(cpu_din), .cpu_opack(cpu_opack),
        .dma_req(dma_req), .dma_rw(dma_rw), .dma_adr(dma_adr), .dma_dout(dma_dout),
        .dma_din(dma_din), .dma_ack(dma_ack), .dma_grant(dma_grant),
        .ext_adr(ext_adr), .ext_dout(ext_dout), .ext_oeb(ext_oeb), .ext_din(ext_din),
        .ext_cs_mem(ext_cs_mem), .ext_cs_io(ext_cs_io), .ext_oe(ext_oe), .ext_we(ext_we),
        .ext_rdy(ext_rdy), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // Access-level model: STROBE ends at the first cycle index that has both
    // served the wait states and seen ext_rdy, unless the watchdog fires first.
    function automatic int strobe_len(input int w, input int n, output logic err);
        int k;
        k = (w > n) ? w : n;
        if (k + 1 > int'(TIMEOUT)) begin
            err = 1'b1;
            return int'(TIMEOUT);
        end
        err = 1'b0;
        return k + 1;
    endfunction

    task automatic apply_reset();
        reset = 1'b1;
        cpu_opreq = 1'b0; cpu_rw = 1'b0; cpu_m_io = 1'b1; cpu_adr = '0; cpu_dout = '0;
        dma_req = 1'b0; dma_rw = 1'b0; dma_adr = '0; dma_dout = '0;
        wait_cfg = '0; ext_din = '0; ext_rdy = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Runs one access from an IDLE cycle (requests already driven), then TURN and IDLE.
    task automatic do_access(input int rdy_low, input logic [DATA_W-1:0] din_val, input int budget);
        m_iter = 0; m_setup = 0; m_strobe = 0; m_oe = 0; m_we = 0; m_csm = 0; m_csio = 0;
        m_oeb = 0; m_grant = 0; m_ack_dma = 1'b0; m_err = 1'b0; m_timed = 1'b1;
        m_din = '0; m_adr = '0; m_dout = '0;
        ext_din = din_val;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (i == 1) begin
                m_adr  = ext_adr;
                m_dout = ext_dout;
            end
            if ((ext_cs_mem || ext_cs_io) && !(ext_oe || ext_we)) m_setup++;
            m_oe    += int'(ext_oe);
            m_we    += int'(ext_we);
            m_csm   += int'(ext_cs_mem);
            m_csio  += int'(ext_cs_io);
            m_oeb   += int'(!ext_oeb);
            m_grant += int'(dma_grant);
            if (ext_oe || ext_we) begin
                ext_rdy  = (m_strobe >= rdy_low);
                wait_cfg = WAIT_W'($urandom);
                m_strobe++;
            end else begin
                ext_rdy = 1'($urandom_range(1));
            end
            if (cpu_opack || dma_ack) begin
                m_iter    = i;
                m_ack_dma = dma_ack;
                m_err     = bus_err;
                m_din     = dma_ack ? dma_din : cpu_din;
                m_timed   = 1'b0;
                break;
            end
        end
        cpu_opreq = 1'b0;
        dma_req   = 1'b0;
        @(negedge clk);
        m_turn_clean = !(ext_cs_mem || ext_cs_io || ext_oe || ext_we || cpu_opack ||
                         dma_ack || dma_grant || bus_err) && ext_oeb;
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({ext_cs_mem, ext_cs_io, ext_oe, ext_we} !== 4'b0) begin
            failures++;
            $display("FAIL reset_strobes got=%b want=0000", {ext_cs_mem, ext_cs_io, ext_oe, ext_we});
        end
        checks++;
        if ({cpu_opack, dma_ack, dma_grant, bus_err} !== 4'b0) begin
            failures++;
            $display("FAIL reset_acks got=%b want=0000", {cpu_opack, dma_ack, dma_grant, bus_err});
        end
        checks++;
        if (ext_oeb !== 1'b1) begin
            failures++;
            $display("FAIL reset_oeb got=%b want=1", ext_oeb);
        end
        checks++;
        if ({ext_adr, ext_dout, cpu_din, dma_din} !== '0) begin
            failures++;
            $display("FAIL reset_data adr=%h dout=%h cdin=%h ddin=%h want=0", ext_adr, ext_dout, cpu_din, dma_din);
        end
    endtask

    task automatic test_cpu_read();
        cpu_opreq = 1'b1; cpu_rw = 1'b0; cpu_m_io = 1'b1; cpu_adr = 13'h0123; wait_cfg = 4'd2;
        do_access(0, 8'hA5, 40);
        checks++;
        if (m_timed || m_ack_dma || m_iter != 5) begin
            failures++;
            $display("FAIL cpu_read_ack timed=%b dma=%b iter=%0d want cpu at 5", m_timed, m_ack_dma, m_iter);
        end
        checks++;
        if (m_din !== 8'hA5 || m_adr !== 13'h0123) begin
            failures++;
            $display("FAIL cpu_read_data din=%h adr=%h want A5/0123", m_din, m_adr);
        end
        checks++;
        if (m_oe != 3 || m_csm != 4 || m_setup != 1 || m_csio != 0 || m_we != 0 || m_oeb != 0) begin
            failures++;
            $display("FAIL cpu_read_strobes oe=%0d csm=%0d setup=%0d csio=%0d we=%0d oeb=%0d want 3/4/1/0/0/0",
                     m_oe, m_csm, m_setup, m_csio, m_we, m_oeb);
        end
        checks++;
        if (!m_turn_clean) begin
            failures++;
            $display("FAIL cpu_read_turn got=not_idle want=idle");
        end
    endtask

    task automatic test_cpu_io_write();
        cpu_opreq = 1'b1; cpu_rw = 1'b1; cpu_m_io = 1'b0; cpu_adr = 13'h1F0A; cpu_dout = 8'h3C;
        wait_cfg = 4'd0;
        do_access(0, 8'h5A, 40);
        checks++;
        if (m_timed || m_iter != 3 || m_ack_dma) begin
            failures++;
            $display("FAIL io_write_ack timed=%b iter=%0d dma=%b want cpu at 3", m_timed, m_iter, m_ack_dma);
        end
        checks++;
        if (m_we != 1 || m_csio != 2 || m_csm != 0 || m_oe != 0 || m_oeb != 3) begin
            failures++;
            $display("FAIL io_write_strobes we=%0d csio=%0d csm=%0d oe=%0d oeb=%0d want 1/2/0/0/3",
                     m_we, m_csio, m_csm, m_oe, m_oeb);
        end
        checks++;
        if (m_dout !== 8'h3C || m_din !== 8'hA5) begin
            failures++;
            $display("FAIL io_write_data dout=%h cpu_din=%h want 3C/A5(held)", m_dout, m_din);
        end
    endtask

    task automatic test_round_robin();
        int   order[$];
        int   grant_cyc, bad;
        logic rr_cpu, rr_dma;
        apply_reset();
        cpu_rw = 1'b0; cpu_m_io = 1'b1; dma_rw = 1'b0; wait_cfg = 4'd0; ext_rdy = 1'b1;
        cpu_opreq = 1'b1; dma_req = 1'b1;
        grant_cyc = 0; bad = 0; rr_cpu = 1'b0; rr_dma = 1'b0;
        for (int i = 0; i < 80 && order.size() < 4; i++) begin
            @(negedge clk);
            if (rr_cpu) cpu_opreq = 1'b1;
            if (rr_dma) dma_req = 1'b1;
            rr_cpu = 1'b0; rr_dma = 1'b0;
            grant_cyc += int'(dma_grant);
            if (dma_grant && ext_cs_io) bad++;
            if ((dma_ack && !dma_grant) || (cpu_opack && dma_grant) || (cpu_opack && dma_ack)) bad++;
            if (cpu_opack) begin order.push_back(0); cpu_opreq = 1'b0; rr_cpu = 1'b1; end
            if (dma_ack)   begin order.push_back(1); dma_req = 1'b0;   rr_dma = 1'b1; end
        end
        cpu_opreq = 1'b0; dma_req = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (order.size() != 4) begin
            failures++;
            $display("FAIL rr_count got=%0d want=4", order.size());
        end else begin
            checks++;
            if (order[0] != 0 || order[1] != 1 || order[2] != 0 || order[3] != 1) begin
                failures++;
                $display("FAIL rr_order got=%0d%0d%0d%0d want=0101 (0=cpu)", order[0], order[1], order[2], order[3]);
            end
        end
        checks++;
        if (bad != 0 || grant_cyc != 6) begin
            failures++;
            $display("FAIL rr_grant bad=%0d grant_cycles=%0d want 0/6", bad, grant_cyc);
        end
    endtask

    task automatic test_dma_rdy_stretch();
        dma_req = 1'b1; dma_rw = 1'b0; dma_adr = 13'h0ABC; wait_cfg = 4'd1;
        do_access(11, 8'h96, 60);
        checks++;
        if (m_timed || !m_ack_dma || m_iter != 14 || m_strobe != 12) begin
            failures++;
            $display("FAIL dma_stretch timed=%b dma=%b iter=%0d strobe=%0d want dma/14/12",
                     m_timed, m_ack_dma, m_iter, m_strobe);
        end
        checks++;
        if (m_din !== 8'h96 || m_grant != 14 || m_csio != 0 || m_err !== 1'b0 || !m_turn_clean) begin
            failures++;
            $display("FAIL dma_stretch_data din=%h grant=%0d csio=%0d err=%b turn=%b want 96/14/0/0/1",
                     m_din, m_grant, m_csio, m_err, m_turn_clean);
        end
    endtask

    task automatic test_timeout();
        cpu_opreq = 1'b1; cpu_rw = 1'b0; cpu_m_io = 1'b1; cpu_adr = 13'h0777; wait_cfg = 4'd3;
        do_access(100000, 8'h12, 400);
        checks++;
        if (m_timed || m_iter != int'(TIMEOUT) + 2 || m_err !== 1'b1 || m_ack_dma) begin
            failures++;
            $display("FAIL timeout_ack timed=%b iter=%0d err=%b dma=%b want cpu err at %0d",
                     m_timed, m_iter, m_err, m_ack_dma, TIMEOUT + 2);
        end
        checks++;
        if (m_din !== 8'hFF || m_oe != int'(TIMEOUT) || !m_turn_clean) begin
            failures++;
            $display("FAIL timeout_data din=%h oe=%0d turn=%b want FF/%0d/1", m_din, m_oe, m_turn_clean, TIMEOUT);
        end
        cpu_opreq = 1'b1; cpu_rw = 1'b0; wait_cfg = 4'd0;
        do_access(0, 8'h44, 40);
        checks++;
        if (m_timed || m_iter != 3 || m_din !== 8'h44 || m_err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_recover iter=%0d din=%h err=%b want 3/44/0", m_iter, m_din, m_err);
        end
    endtask

    task automatic test_reset_mid_access();
        logic seen;
        seen = 1'b0;
        cpu_opreq = 1'b1; cpu_rw = 1'b1; cpu_m_io = 1'b1; cpu_dout = 8'hC3; wait_cfg = 4'd5;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = ext_we;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL reset_mid_we got=no_strobe want=strobe");
        end
        reset = 1'b1;
        cpu_opreq = 1'b0;
        #1;
        checks++;
        if ({ext_we, ext_cs_mem, cpu_opack, ext_oeb} !== 4'b0001) begin
            failures++;
            $display("FAIL reset_mid_outputs we/cs/ack/oeb got=%b want=0001", {ext_we, ext_cs_mem, cpu_opack, ext_oeb});
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (cpu_opack !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_noack got=%b want=0", cpu_opack);
        end
        cpu_opreq = 1'b1; cpu_rw = 1'b0; wait_cfg = 4'd0;
        do_access(0, 8'h81, 40);
        checks++;
        if (m_timed || m_iter != 3 || m_setup != 1 || m_din !== 8'h81) begin
            failures++;
            $display("FAIL reset_mid_next iter=%0d setup=%0d din=%h want 3/1/81", m_iter, m_setup, m_din);
        end
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] exp_cpu, exp_dma, dv, ov, exp_din;
        logic [ADR_W-1:0]  a;
        logic              dma, rw, mem, e;
        int                w, n, len;
        apply_reset();
        exp_cpu = '0; exp_dma = '0;
        for (int i = 0; i < 40; i++) begin
            dma = 1'($urandom_range(1));
            rw  = 1'($urandom_range(1));
            mem = dma ? 1'b1 : 1'($urandom_range(1));
            a   = ADR_W'($urandom);
            ov  = DATA_W'($urandom);
            dv  = DATA_W'($urandom);
            w   = $urandom_range(15);
            n   = ($urandom_range(3) == 0) ? $urandom_range(20) : 0;
            len = strobe_len(w, n, e);
            cpu_adr = ADR_W'($urandom); cpu_dout = DATA_W'($urandom); cpu_rw = 1'($urandom); cpu_m_io = 1'($urandom);
            dma_adr = ADR_W'($urandom); dma_dout = DATA_W'($urandom); dma_rw = 1'($urandom);
            if (dma) begin
                dma_req = 1'b1; dma_rw = rw; dma_adr = a; dma_dout = ov;
            end else begin
                cpu_opreq = 1'b1; cpu_rw = rw; cpu_m_io = mem; cpu_adr = a; cpu_dout = ov;
            end
            wait_cfg = WAIT_W'(w);
            do_access(n, dv, 80);
            if (!rw) begin
                if (dma) exp_dma = dv;
                else     exp_cpu = dv;
            end
            exp_din = dma ? exp_dma : exp_cpu;
            checks++;
            if (m_timed || m_iter != len + 2 || m_ack_dma !== dma || m_err !== e) begin
                failures++;
                $display("FAIL rand%0d_ack timed=%b iter=%0d dma=%b err=%b want %0d/%b/%b",
                         i, m_timed, m_iter, m_ack_dma, m_err, len + 2, dma, e);
            end
            checks++;
            if (m_din !== exp_din || m_adr !== a || m_dout !== ov) begin
                failures++;
                $display("FAIL rand%0d_data din=%h adr=%h dout=%h want %h/%h/%h",
                         i, m_din, m_adr, m_dout, exp_din, a, ov);
            end
            checks++;
            if (m_oe != (rw ? 0 : len) || m_we != (rw ? len : 0) || m_csm != (mem ? len + 1 : 0) ||
                m_csio != (mem ? 0 : len + 1) || m_oeb != (rw ? len + 2 : 0) ||
                m_grant != (dma ? len + 2 : 0) || !m_turn_clean) begin
                failures++;
                $display("FAIL rand%0d_strobes oe=%0d we=%0d csm=%0d csio=%0d oeb=%0d grant=%0d turn=%b len=%0d rw=%b mem=%b dma=%b",
                         i, m_oe, m_we, m_csm, m_csio, m_oeb, m_grant, m_turn_clean, len, rw, mem, dma);
            end
        end
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_cpu_io_write();
        test_round_robin();
        test_dma_rdy_stretch();
        test_timeout();
        test_reset_mid_access();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout reached=2ms want=finish_before");
        $fatal(1, "bench did not finish");
    end

endmodule
